// File: rtl/tcp_rx_sync_arb.sv
// rtl/tcp_rx_sync_arb.sv - round-robin write-side scheduler for the TCP RX message/cell FIFO pair
// One grant moves one packet: the grantee's cells are written first, then its message.
module tcp_rx_sync_arb #(
  parameter int SRC_NUM    = 4,
  parameter int INFO_WID   = 8,
  parameter int CDWID      = 128,
  parameter int MAX_CELLSZ = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SRC_NUM-1:0]          src_msg_vld,
  output logic [SRC_NUM-1:0]          src_msg_rdy,
  input  logic [SRC_NUM*INFO_WID-1:0] src_msg_dat,
  input  logic [SRC_NUM-1:0]          src_cpkt_vld,
  input  logic [SRC_NUM-1:0]          src_cpkt_last,
  output logic [SRC_NUM-1:0]          src_cpkt_rdy,
  input  logic [SRC_NUM*CDWID-1:0]    src_cpkt_dat,
  output logic                        out_msg_wr,
  output logic [INFO_WID-1:0]         out_msg_wdata,
  input  logic                        out_msg_afull,
  output logic                        out_cpkt_wr,
  output logic [CDWID:0]              out_cpkt_wdata,
  input  logic                        out_cpkt_afull,
  output logic                        err_ovl,
  output logic [2:0]                  grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    CELL,
    DROP,
    MSG
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(MAX_CELLSZ - 1);
  localparam logic [2:0]  LAST_SRC = 3'(SRC_NUM - 1);

  state_t               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 msg_wr_q, msg_wr_d;
  logic [INFO_WID-1:0]  msg_wdata_q, msg_wdata_d;
  logic                 cpkt_wr_q, cpkt_wr_d;
  logic [CDWID:0]       cpkt_wdata_q, cpkt_wdata_d;
  logic                 err_q, err_d;

  logic [SRC_NUM-1:0]   gnt_oh;
  logic                 g_msg_vld;
  logic                 g_cpkt_vld;
  logic                 g_cpkt_last;
  logic [INFO_WID-1:0]  g_msg_dat;
  logic [CDWID-1:0]     g_cpkt_dat;
  logic [2:0]           winner;
  logic                 found;

  // Grantee view of the producer buses
  always_comb begin
    gnt_oh     = '0;
    g_msg_dat  = '0;
    g_cpkt_dat = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (grant_q == 3'(i)) begin
        gnt_oh[i]  = 1'b1;
        g_msg_dat  = src_msg_dat[i*INFO_WID +: INFO_WID];
        g_cpkt_dat = src_cpkt_dat[i*CDWID +: CDWID];
      end
    end
  end

  assign g_msg_vld   = |(src_msg_vld & gnt_oh);
  assign g_cpkt_vld  = |(src_cpkt_vld & gnt_oh);
  assign g_cpkt_last = |(src_cpkt_last & gnt_oh);

  // First requester at or after rr_ptr, wrapping modulo SRC_NUM
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < SRC_NUM; k++) begin
      for (int i = 0; i < SRC_NUM; i++) begin
        if (!found && src_msg_vld[i] && (i == (int'(rr_ptr_q) + k) % SRC_NUM)) begin
          found  = 1'b1;
          winner = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    msg_wr_d     = 1'b0;
    msg_wdata_d  = msg_wdata_q;
    cpkt_wr_d    = 1'b0;
    cpkt_wdata_d = cpkt_wdata_q;
    err_d        = 1'b0;
    src_msg_rdy  = '0;
    src_cpkt_rdy = '0;

    case (state_q)
      IDLE: begin
        if (found && !out_msg_afull && !out_cpkt_afull) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = CELL;
        end
      end

      CELL: begin
        src_cpkt_rdy = out_cpkt_afull ? '0 : gnt_oh;
        if (g_cpkt_vld && !out_cpkt_afull) begin
          cnt_d        = cnt_q + 16'd1;
          cpkt_wr_d    = 1'b1;
          cpkt_wdata_d = {g_cpkt_last, g_cpkt_dat};
          if (g_cpkt_last) begin
            state_d = MSG;
          end else if (cnt_q == LAST_CNT) begin
            // Truncate: close the cell stream here and swallow the remainder
            err_d                = 1'b1;
            cpkt_wdata_d[CDWID]  = 1'b1;
            state_d              = DROP;
          end
        end
      end

      DROP: begin
        src_cpkt_rdy = gnt_oh;
        if (g_cpkt_vld && g_cpkt_last) begin
          state_d = MSG;
        end
      end

      MSG: begin
        src_msg_rdy = out_msg_afull ? '0 : gnt_oh;
        if (g_msg_vld && !out_msg_afull) begin
          msg_wr_d    = 1'b1;
          msg_wdata_d = g_msg_dat;
          rr_ptr_d    = (grant_q == LAST_SRC) ? 3'd0 : grant_q + 3'd1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      msg_wr_q     <= 1'b0;
      msg_wdata_q  <= '0;
      cpkt_wr_q    <= 1'b0;
      cpkt_wdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      msg_wr_q     <= msg_wr_d;
      msg_wdata_q  <= msg_wdata_d;
      cpkt_wr_q    <= cpkt_wr_d;
      cpkt_wdata_q <= cpkt_wdata_d;
      err_q        <= err_d;
    end
  end

  assign out_msg_wr     = msg_wr_q;
  assign out_msg_wdata  = msg_wdata_q;
  assign out_cpkt_wr    = cpkt_wr_q;
  assign out_cpkt_wdata = cpkt_wdata_q;
  assign err_ovl        = err_q;
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_tcp_rx_sync_arb.sv
// tb/tb_tcp_rx_sync_arb.sv - packet-table and scoreboard bench for tcp_rx_sync_arb
module tb_tcp_rx_sync_arb;
  localparam int SRC = 4;
  localparam int IW  = 8;
  localparam int CW  = 128;
  localparam int MCS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [SRC-1:0]      src_msg_vld = '0;
  logic [SRC-1:0]      src_msg_rdy;
  logic [SRC*IW-1:0]   src_msg_dat = '0;
  logic [SRC-1:0]      src_cpkt_vld = '0;
  logic [SRC-1:0]      src_cpkt_last = '0;
  logic [SRC-1:0]      src_cpkt_rdy;
  logic [SRC*CW-1:0]   src_cpkt_dat = '0;
  logic                out_msg_wr;
  logic [IW-1:0]       out_msg_wdata;
  logic                out_msg_afull = 1'b0;
  logic                out_cpkt_wr;
  logic [CW:0]         out_cpkt_wdata;
  logic                out_cpkt_afull = 1'b0;
  logic                err_ovl;
  logic [2:0]          grant_id;

  tcp_rx_sync_arb #(.SRC_NUM(SRC), .INFO_WID(IW), .CDWID(CW), .MAX_CELLSZ(MCS)) dut (
    .clk(clk), .rst(rst),
    .src_msg_vld(src_msg_vld), .src_msg_rdy(src_msg_rdy), .src_msg_dat(src_msg_dat),
    .src_cpkt_vld(src_cpkt_vld), .src_cpkt_last(src_cpkt_last),
    .src_cpkt_rdy(src_cpkt_rdy), .src_cpkt_dat(src_cpkt_dat),
    .out_msg_wr(out_msg_wr), .out_msg_wdata(out_msg_wdata), .out_msg_afull(out_msg_afull),
    .out_cpkt_wr(out_cpkt_wr), .out_cpkt_wdata(out_cpkt_wdata), .out_cpkt_afull(out_cpkt_afull),
    .err_ovl(err_ovl), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct { int src; int ncells; logic [7:0] msg; int exp_wr; bit exp_err; } vec_t;
  typedef struct { int src; logic [CW-1:0] dat; logic last; } cell_t;
  typedef struct { int src; logic [IW-1:0] msg; } msg_t;
  typedef struct { bit is_msg; logic [CW:0] data; bit err; } ev_t;

  vec_t  tbl[14];
  cell_t cq[$];
  msg_t  mq[$];
  ev_t   expq[$];
  int    msg_cycs[$];
  int    nvec = 0, nfail = 0, cyc = 0, last_cell_cyc = 0, err_cnt = 0;
  bit    tight = 1'b0, rec_msg = 1'b0, prev_open = 1'b0;
  logic [SRC-1:0] acc_cell = '0, acc_msg = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cfront(input int s);
    for (int k = 0; k < cq.size(); k++) if (cq[k].src == s) return k;
    return -1;
  endfunction

  function automatic int ccount(input int s);
    int n = 0;
    for (int k = 0; k < cq.size(); k++) if (cq[k].src == s) n++;
    return n;
  endfunction

  function automatic int mfront(input int s);
    for (int k = 0; k < mq.size(); k++) if (mq[k].src == s) return k;
    return -1;
  endfunction

  // Producer stimulus plus the writes the FIFOs must see for it, in grant order
  task automatic load_pkt(input vec_t v, input int pid);
    cell_t c;
    msg_t  m;
    ev_t   e;
    for (int j = 0; j < v.ncells; j++) begin
      c.src  = v.src;
      c.dat  = {$urandom, $urandom, $urandom, 8'(v.src), 8'(pid), 8'(j), 8'hC5};
      c.last = (j == v.ncells - 1);
      cq.push_back(c);
      if (j < v.exp_wr) begin
        e.is_msg = 1'b0;
        e.data   = {(j == v.exp_wr - 1), c.dat};
        e.err    = v.exp_err && (j == v.exp_wr - 1);
        expq.push_back(e);
      end
    end
    m.src = v.src;
    m.msg = v.msg;
    mq.push_back(m);
    e.is_msg = 1'b1;
    e.data   = {{(CW + 1 - IW){1'b0}}, v.msg};
    e.err    = 1'b0;
    expq.push_back(e);
  endtask

  task automatic drive();
    int k;
    for (int i = 0; i < SRC; i++) begin
      k = cfront(i);
      if (k >= 0) begin
        src_cpkt_vld[i]             = 1'b1;
        src_cpkt_last[i]            = cq[k].last;
        src_cpkt_dat[i*CW +: CW]    = cq[k].dat;
      end else begin
        src_cpkt_vld[i]             = 1'b0;
        src_cpkt_last[i]            = 1'b0;
        src_cpkt_dat[i*CW +: CW]    = '0;
      end
      k = mfront(i);
      if (k >= 0) begin
        src_msg_vld[i]           = 1'b1;
        src_msg_dat[i*IW +: IW]  = mq[k].msg;
      end else begin
        src_msg_vld[i]           = 1'b0;
        src_msg_dat[i*IW +: IW]  = '0;
      end
    end
  endtask

  task automatic sample();
    ev_t e;
    @(negedge clk);
    if (out_cpkt_wr || out_msg_wr) begin
      if (expq.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexp_wr: cell_wr %0b msg_wr %0b with no write expected (cycle %0d)",
                 out_cpkt_wr, out_msg_wr, cyc);
      end else begin
        e = expq.pop_front();
        chk("wr_kind", {out_msg_wr, out_cpkt_wr}, e.is_msg ? 2'b10 : 2'b01);
        if (e.is_msg) chk("msg_wdata", out_msg_wdata, e.data[IW-1:0]);
        else          chk("cpkt_wdata", out_cpkt_wdata, e.data);
        chk("err_ovl", err_ovl, e.err);
      end
      if (out_cpkt_wr) begin
        if (tight && prev_open) chk("cell_gap", cyc - last_cell_cyc, 1);
        prev_open     = !out_cpkt_wdata[CW];
        last_cell_cyc = cyc;
      end
      if (out_msg_wr) begin
        if (tight) chk("msg_after_cell", cyc - last_cell_cyc, 1);
        if (rec_msg) msg_cycs.push_back(cyc);
      end
    end else if (err_ovl) begin
      nvec++;
      nfail++;
      $display("FAIL err_alone: err_ovl 1 without a cell write, required 0 (cycle %0d)", cyc);
    end
    if (err_ovl) err_cnt++;
    acc_cell = src_cpkt_vld & src_cpkt_rdy;
    acc_msg  = src_msg_vld & src_msg_rdy;
    for (int i = 0; i < SRC; i++) if (acc_msg[i]) chk("grant_id", grant_id, 3'(i));
  endtask

  task automatic advance();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < SRC; i++) begin
      if (acc_cell[i]) begin k = cfront(i); if (k >= 0) cq.delete(k); end
      if (acc_msg[i])  begin k = mfront(i); if (k >= 0) mq.delete(k); end
    end
    drive();
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((expq.size() != 0 || cq.size() != 0 || mq.size() != 0) && n < limit) begin
      sample();
      advance();
      n++;
    end
    chk({name, "_done"}, (n < limit), 1'b1);
    repeat (2) begin sample(); advance(); end
  endtask

  function automatic logic [159:0] all_outs();
    return {out_msg_wr, out_msg_wdata, out_cpkt_wr, out_cpkt_wdata, err_ovl, grant_id,
            src_msg_rdy, src_cpkt_rdy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int e0;
    tbl[0]  = '{0, 1, 8'h10, 1, 1'b0};
    tbl[1]  = '{1, 1, 8'h11, 1, 1'b0};
    tbl[2]  = '{2, 1, 8'h12, 1, 1'b0};
    tbl[3]  = '{3, 1, 8'h13, 1, 1'b0};
    tbl[4]  = '{0, 1, 8'h14, 1, 1'b0};
    tbl[5]  = '{2, 3, 8'h5A, 3, 1'b0};
    tbl[6]  = '{1, 3, 8'h21, 3, 1'b0};
    tbl[7]  = '{0, 2, 8'h30, 2, 1'b0};
    tbl[8]  = '{1, 6, 8'h61, 4, 1'b1};
    tbl[9]  = '{2, 1, 8'h72, 1, 1'b0};
    tbl[10] = '{3, 3, 8'h83, 3, 1'b0};
    tbl[11] = '{0, 1, 8'h90, 1, 1'b0};
    tbl[12] = '{3, 2, 8'h93, 2, 1'b0};
    tbl[13] = '{0, 4, 8'hA4, 4, 1'b0};

    // Reset with every producer requesting, then round robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) load_pkt(tbl[k], k);
    drive();
    repeat (3) begin
      sample();
      chk("reset_outs", all_outs(), '0);
      advance();
    end
    rst = 1'b0;
    tight = 1'b1;
    rec_msg = 1'b1;
    drain("rr", 60);
    tight = 1'b0;
    rec_msg = 1'b0;
    chk("rr_msgs", msg_cycs.size(), 5);
    for (int k = 0; k + 1 < msg_cycs.size(); k++) chk("rr_period", msg_cycs[k+1] - msg_cycs[k], 3);

    // Three back-to-back cells then message 0x5A
    tight = 1'b1;
    load_pkt(tbl[5], 5);
    drain("multi", 30);
    tight = 1'b0;

    // Cell FIFO almost full for five cycles after cell 1
    load_pkt(tbl[6], 6);
    n = 0;
    while (ccount(1) != 2 && n < 20) begin sample(); advance(); n++; end
    chk("bp_reach", ccount(1), 2);
    out_cpkt_afull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("bp_rdy", src_cpkt_rdy, '0);
      if (k > 0) chk("bp_nowr", out_cpkt_wr, 1'b0);
      chk("bp_held", ccount(1), 2);
      advance();
    end
    out_cpkt_afull = 1'b0;
    sample();
    chk("bp_resume_rdy", src_cpkt_rdy, 4'b0010);
    chk("bp_post_nowr", out_cpkt_wr, 1'b0);
    advance();
    drain("bp", 30);

    // Message FIFO almost full in IDLE blocks arbitration
    out_msg_afull = 1'b1;
    load_pkt(tbl[7], 7);
    drive();
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("afull_idle_rdy", {src_msg_rdy, src_cpkt_rdy}, '0);
      chk("afull_idle_wr", {out_msg_wr, out_cpkt_wr}, 2'b00);
      advance();
    end
    out_msg_afull = 1'b0;
    drain("afull_idle", 30);

    // Six cells against a four-cell limit
    e0 = err_cnt;
    load_pkt(tbl[8], 8);
    drain("ovl", 40);
    chk("ovl_pulses", err_cnt - e0, 1);

    // Reset in the middle of a source-3 packet with rr_ptr at 3
    load_pkt(tbl[9], 9);
    drain("pre_rst", 20);
    load_pkt(tbl[10], 10);
    drive();
    n = 0;
    while (ccount(3) != 2 && n < 20) begin sample(); advance(); n++; end
    chk("rst_mid_reach", ccount(3), 2);
    rst = 1'b1;
    expq.delete();
    cq.delete();
    mq.delete();
    drive();
    sample();
    chk("rst_mid_outs", all_outs(), '0);
    advance();
    sample();
    chk("rst_mid_hold", all_outs(), '0);
    advance();
    rst = 1'b0;
    load_pkt(tbl[11], 11);
    load_pkt(tbl[12], 12);
    drive();
    drain("post_rst", 40);

    // Exactly MAX_CELLSZ cells ending on last: no truncation
    e0 = err_cnt;
    load_pkt(tbl[13], 13);
    drive();
    drain("max_exact", 30);
    chk("max_exact_noerr", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
